tinker_fetch_unit: RTL and testbench

- Instruction-supply side of the tinker_core instruction interface.
- Owns the PC, issues 32-bit instruction reads to instruction memory over a valid/ready request + valid response channel, and buffers returned words in a small FIFO.
- Presents words to the decode stage with a valid/ready handshake and the matching PC.
- Accepts PC redirects (branch/jump/return) and discards wrong-path fetches.

---
 rtl/tinker_fetch_unit.sv | 177 +++++++++++++++++
 tb/tb_tinker_fetch_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/tinker_fetch_unit.sv
// tinker_fetch_unit: instruction-supply side of the tinker_core front end.
// Owns the PC and issues one 32-bit instruction read at a time. Returned
// words go into a small FIFO that the decode stage drains.
// Redirects reload the PC, flush the FIFO and discard any in-flight
// (wrong-path) response.
//
// Handshake semantics, shared by every channel in this block:
//   - A transfer happens on a rising edge where valid && ready.
//   - Once valid is raised, it and its payload are held stable until that
//     transfer occurs. The only exception is inst_*, which a redirect or a
//     reset may drop.
//   - valid never depends combinationally on ready.
//   - mem_rsp_valid has no ready: it is a one-cycle, in-order pulse that
//     belongs to the single outstanding request.
module tinker_fetch_unit #(
    parameter int                ADDR_W     = 64,
    parameter logic [ADDR_W-1:0] RESET_PC   = 'h2000,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [31:0]       mem_rsp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst_data,
    output logic [ADDR_W-1:0] inst_pc
);

    localparam int                PTR_W       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int                CNT_W       = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C     = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] ALIGN_MASK  = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] RESET_PC_AL = RESET_PC & ALIGN_MASK;
    localparam logic [ADDR_W-1:0] PC_STEP     = ADDR_W'(4);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    // The outstanding request belongs to a path that was redirected away.
    logic              stale;

    logic [31:0]       fifo_data [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_pc   [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;

    logic              rsp_fire;
    logic              push;
    logic              pop;
    logic [CNT_W-1:0]  count_after_push;
    logic [ADDR_W-1:0] redirect_aligned;

    // A response is only meaningful while waiting. It is kept only when
    // it is on the current path and no redirect lands in the same cycle.
    assign rsp_fire         = (state == WAIT) && mem_rsp_valid;
    assign push             = rsp_fire && !stale && !redirect_valid;
    assign pop              = inst_valid && inst_ready;
    assign count_after_push = count + CNT_W'(push);
    assign redirect_aligned = redirect_pc & ALIGN_MASK;

    // The FIFO head is presented straight from storage registers, so no
    // path runs from mem_rsp_* to inst_*.
    assign inst_valid = (count != '0);
    assign inst_data  = fifo_data[rd_ptr];
    assign inst_pc    = fifo_pc[rd_ptr];

    // Request FSM: PC ownership, request issue and stale tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            pc            <= RESET_PC_AL;
            stale         <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= RESET_PC_AL;
        end else begin
            case (state)
                IDLE: begin
                    // A redirect flushes the FIFO, so there is always room
                    // to fetch the target in the very next cycle.
                    if (redirect_valid) begin
                        pc            <= redirect_aligned;
                        mem_req_valid <= 1'b1;
                        mem_req_addr  <= redirect_aligned;
                        state         <= REQ;
                    end else if (count < DEPTH_C) begin
                        mem_req_valid <= 1'b1;
                        mem_req_addr  <= pc;
                        state         <= REQ;
                    end
                end
                REQ: begin
                    // The request is never withdrawn. A redirect only marks
                    // it stale so that its response is thrown away later.
                    if (redirect_valid) begin
                        pc    <= redirect_aligned;
                        stale <= 1'b1;
                    end
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= WAIT;
                        // pc already points past a stale request's address,
                        // so only a current-path handshake advances it.
                        if (!redirect_valid && !stale) begin
                            pc <= pc + PC_STEP;
                        end
                    end
                end
                WAIT: begin
                    if (mem_rsp_valid) begin
                        stale <= 1'b0;
                        if (redirect_valid) begin
                            pc            <= redirect_aligned;
                            mem_req_valid <= 1'b1;
                            mem_req_addr  <= redirect_aligned;
                            state         <= REQ;
                        end else if (count_after_push < DEPTH_C) begin
                            mem_req_valid <= 1'b1;
                            mem_req_addr  <= pc;
                            state         <= REQ;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (redirect_valid) begin
                        pc    <= redirect_aligned;
                        stale <= 1'b1;
                    end
                end
                default: begin
                    state         <= IDLE;
                    mem_req_valid <= 1'b0;
                end
            endcase
        end
    end

    // Instruction FIFO: push accepted responses, pop on decode handshake, flush on redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data[i] <= '0;
                fifo_pc[i]   <= '0;
            end
        end else if (redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= mem_rsp_data;
                // mem_req_addr still holds the address of the request that
                // this response answers.
                fifo_pc[wr_ptr]   <= mem_req_addr;
                wr_ptr            <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

endmodule

// File: tb/tb_tinker_fetch_unit.sv
// Testbench for tinker_fetch_unit. It steps the design one clock per
// vector. Each vector gives the inputs held through that cycle and the
// outputs expected during it. The expected outputs reflect the state
// registered at the preceding edge.
module tb_tinker_fetch_unit;

  localparam int ADDR_W = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset = 1'b1;
  logic              mem_req_valid;
  logic              mem_req_ready = 1'b0;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_rsp_valid = 1'b0;
  logic [31:0]       mem_rsp_data = 32'h0;
  logic              redirect_valid = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = 64'h0;
  logic              inst_valid;
  logic              inst_ready = 1'b0;
  logic [31:0]       inst_data;
  logic [ADDR_W-1:0] inst_pc;

  tinker_fetch_unit #(
    .ADDR_W(ADDR_W),
    .RESET_PC(64'h2000),
    .FIFO_DEPTH(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .inst_data(inst_data),
    .inst_pc(inst_pc)
  );

  // ---------------- vector records ----------------
  // chk: 0 = no check, 1 = check valids (payload only where valid),
  // 2 = check every output field.
  typedef struct {
    string       tag;
    logic        rst;
    logic        rdy;
    logic        rspv;
    logic [31:0] rspd;
    logic        redir;
    logic [63:0] rpc;
    logic        irdy;
    int          chk;
    logic        erv;
    logic [63:0] eaddr;
    logic        eiv;
    logic [31:0] edata;
    logic [63:0] epc;
  } vec_t;

  vec_t vecs[$];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic vec_t mk(input string tag, input int rst, input int rdy, input int rspv,
                              input logic [31:0] rspd, input int redir, input logic [63:0] rpc,
                              input int irdy, input int chk, input int erv, input logic [63:0] eaddr,
                              input int eiv, input logic [31:0] edata, input logic [63:0] epc);
    vec_t v;
    v.tag   = tag;
    v.rst   = (rst != 0);
    v.rdy   = (rdy != 0);
    v.rspv  = (rspv != 0);
    v.rspd  = rspd;
    v.redir = (redir != 0);
    v.rpc   = rpc;
    v.irdy  = (irdy != 0);
    v.chk   = chk;
    v.erv   = (erv != 0);
    v.eaddr = eaddr;
    v.eiv   = (eiv != 0);
    v.edata = edata;
    v.epc   = epc;
    return v;
  endfunction

  // ---------------- scoreboard compare ----------------
  task automatic cmp(input string tag, input string what, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s %s: got %0h expected %0h", tag, what, got, exp);
    end
  endtask

  // ---------------- driver: one vector per cycle ----------------
  // Entered and left at posedge+1.
  task automatic apply_vec(input vec_t v);
    reset          = v.rst;
    mem_req_ready  = v.rdy;
    mem_rsp_valid  = v.rspv;
    mem_rsp_data   = v.rspd;
    redirect_valid = v.redir;
    redirect_pc    = v.rpc;
    inst_ready     = v.irdy;
    #1;
    if (v.chk != 0) begin
      cmp(v.tag, "mem_req_valid", 64'(mem_req_valid), 64'(v.erv));
      if (v.erv || v.chk == 2) cmp(v.tag, "mem_req_addr", mem_req_addr, v.eaddr);
      cmp(v.tag, "inst_valid", 64'(inst_valid), 64'(v.eiv));
      if (v.eiv || v.chk == 2) begin
        cmp(v.tag, "inst_data", 64'(inst_data), 64'(v.edata));
        cmp(v.tag, "inst_pc", inst_pc, v.epc);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Hard stop if the run ever hangs.
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            tag    rst rdy rv rsp_data      rd redirect_pc     ir chk erv req_addr       eiv inst_data    inst_pc
    // A: zero-wait memory, decoder always ready
    vecs.push_back(mk("A0", 1, 0, 0, 32'h0,        0, 64'h0,          0, 0, 0, 64'h0,          0, 32'h0,        64'h0));
    vecs.push_back(mk("A1", 0, 1, 0, 32'h0,        0, 64'h0,          1, 2, 0, 64'h2000,       0, 32'h0,        64'h0));
    vecs.push_back(mk("A2", 0, 1, 0, 32'h0,        0, 64'h0,          1, 1, 1, 64'h2000,       0, 32'h0,        64'h0));
    vecs.push_back(mk("A3", 0, 1, 1, 32'hC8000000, 0, 64'h0,          1, 1, 0, 64'h0,          0, 32'h0,        64'h0));
    vecs.push_back(mk("A4", 0, 1, 0, 32'h0,        0, 64'h0,          1, 1, 1, 64'h2004,       1, 32'hC8000000, 64'h2000));
    vecs.push_back(mk("A5", 0, 1, 1, 32'hC8400000, 0, 64'h0,          1, 1, 0, 64'h0,          0, 32'h0,        64'h0));
    vecs.push_back(mk("A6", 0, 0, 0, 32'h0,        0, 64'h0,          1, 1, 1, 64'h2008,       1, 32'hC8400000, 64'h2004));
    vecs.push_back(mk("A7", 0, 0, 0, 32'h0,        0, 64'h0,          1, 1, 1, 64'h2008,       0, 32'h0,        64'h0));
    // B: decoder stalled, FIFO fills to two entries and issue stops
    vecs.push_back(mk("B0", 1, 0, 0, 32'h0,        0, 64'h0,          0, 0, 0, 64'h0,          0, 32'h0,        64'h0));
    vecs.push_back(mk("B1", 0, 1, 0, 32'h0,        0, 64'h0,          0, 1, 0, 64'h0,          0, 32'h0,        64'h0));
    vecs.push_back(mk("B2", 0, 1, 0, 32'h0,        0, 64'h0,          0, 1, 1, 64'h2000,       0, 32'h0,        64'h0));
    vecs.push_back(mk("B3", 0, 1, 1, 32'h11111111, 0, 64'h0,          0, 1, 0, 64'h0,          0, 32'h0,        64'h0));
    vecs.push_back(mk("B4", 0, 1, 0, 32'h0,        0, 64'h0,          0, 1, 1, 64'h2004,       1, 32'h11111111, 64'h2000));
    vecs.push_back(mk("B5", 0, 1, 1, 32'h22222222, 0, 64'h0,          0, 1, 0, 64'h0,          1, 32'h11111111, 64'h2000));
    vecs.push_back(mk("B6", 0, 1, 0, 32'h0,        0, 64'h0,          0, 1, 0, 64'h0,          1, 32'h11111111, 64'h2000));
    vecs.push_back(mk("B7", 0, 1, 0, 32'h0,        0, 64'h0,          0, 1, 0, 64'h0,          1, 32'h11111111, 64'h2000));
    vecs.push_back(mk("B8", 0, 1, 0, 32'h0,        0, 64'h0,          1, 1, 0, 64'h0,          1, 32'h11111111, 64'h2000));
    vecs.push_back(mk("B9", 0, 0, 0, 32'h0,        0, 64'h0,          0, 1, 0, 64'h0,          1, 32'h22222222, 64'h2004));
    vecs.push_back(mk("B10",0, 0, 0, 32'h0,        0, 64'h0,          0, 1, 1, 64'h2008,       1, 32'h22222222, 64'h2004));
    // D: redirect to an unaligned target while waiting on 0x2004
    vecs.push_back(mk("D0", 1, 0, 0, 32'h0,        0, 64'h0,          0, 0, 0, 64'h0,          0, 32'h0,        64'h0));
    vecs.push_back(mk("D1", 0, 1, 0, 32'h0,        0, 64'h0,          0, 1, 0, 64'h0,          0, 32'h0,        64'h0));
    vecs.push_back(mk("D2", 0, 1, 0, 32'h0,        0, 64'h0,          0, 1, 1, 64'h2000,       0, 32'h0,        64'h0));
    vecs.push_back(mk("D3", 0, 1, 1, 32'hC8000000, 0, 64'h0,          0, 1, 0, 64'h0,          0, 32'h0,        64'h0));
    vecs.push_back(mk("D4", 0, 1, 0, 32'h0,        0, 64'h0,          0, 1, 1, 64'h2004,       1, 32'hC8000000, 64'h2000));
    vecs.push_back(mk("D5", 0, 1, 0, 32'h0,        1, 64'h3002,       0, 1, 0, 64'h0,          1, 32'hC8000000, 64'h2000));
    vecs.push_back(mk("D6", 0, 1, 1, 32'hC8400000, 0, 64'h0,          0, 1, 0, 64'h0,          0, 32'h0,        64'h0));
    vecs.push_back(mk("D7", 0, 1, 0, 32'h0,        0, 64'h0,          0, 1, 1, 64'h3000,       0, 32'h0,        64'h0));
    vecs.push_back(mk("D8", 0, 1, 1, 32'h33333333, 0, 64'h0,          0, 1, 0, 64'h0,          0, 32'h0,        64'h0));
    vecs.push_back(mk("D9", 0, 0, 0, 32'h0,        0, 64'h0,          1, 1, 1, 64'h3004,       1, 32'h33333333, 64'h3000));
    vecs.push_back(mk("D10",0, 0, 0, 32'h0,        0, 64'h0,          0, 1, 1, 64'h3004,       0, 32'h0,        64'h0));
    // E: redirect in the same cycle as a response and an inst handshake
    vecs.push_back(mk("E0", 1, 0, 0, 32'h0,        0, 64'h0,          0, 0, 0, 64'h0,          0, 32'h0,        64'h0));
    vecs.push_back(mk("E1", 0, 1, 0, 32'h0,        0, 64'h0,          0, 1, 0, 64'h0,          0, 32'h0,        64'h0));
    vecs.push_back(mk("E2", 0, 1, 0, 32'h0,        0, 64'h0,          0, 1, 1, 64'h2000,       0, 32'h0,        64'h0));
    vecs.push_back(mk("E3", 0, 1, 1, 32'h44444444, 0, 64'h0,          0, 1, 0, 64'h0,          0, 32'h0,        64'h0));
    vecs.push_back(mk("E4", 0, 1, 0, 32'h0,        0, 64'h0,          0, 1, 1, 64'h2004,       1, 32'h44444444, 64'h2000));
    vecs.push_back(mk("E5", 0, 1, 1, 32'h55555555, 1, 64'h4000,       1, 1, 0, 64'h0,          1, 32'h44444444, 64'h2000));
    vecs.push_back(mk("E6", 0, 1, 0, 32'h0,        0, 64'h0,          1, 1, 1, 64'h4000,       0, 32'h0,        64'h0));
    vecs.push_back(mk("E7", 0, 1, 1, 32'h66666666, 0, 64'h0,          1, 1, 0, 64'h0,          0, 32'h0,        64'h0));
    vecs.push_back(mk("E8", 0, 0, 0, 32'h0,        0, 64'h0,          1, 1, 1, 64'h4004,       1, 32'h66666666, 64'h4000));
    vecs.push_back(mk("E9", 0, 0, 0, 32'h0,        0, 64'h0,          0, 1, 1, 64'h4004,       0, 32'h0,        64'h0));
    // F: reset while in REQ with a buffered entry
    vecs.push_back(mk("F0", 1, 0, 0, 32'h0,        0, 64'h0,          0, 0, 0, 64'h0,          0, 32'h0,        64'h0));
    vecs.push_back(mk("F1", 0, 1, 0, 32'h0,        0, 64'h0,          0, 1, 0, 64'h0,          0, 32'h0,        64'h0));
    vecs.push_back(mk("F2", 0, 1, 0, 32'h0,        0, 64'h0,          0, 1, 1, 64'h2000,       0, 32'h0,        64'h0));
    vecs.push_back(mk("F3", 0, 1, 1, 32'h77777777, 0, 64'h0,          0, 1, 0, 64'h0,          0, 32'h0,        64'h0));
    vecs.push_back(mk("F4", 0, 0, 0, 32'h0,        0, 64'h0,          0, 1, 1, 64'h2004,       1, 32'h77777777, 64'h2000));
    vecs.push_back(mk("F5", 1, 0, 0, 32'h0,        0, 64'h0,          0, 1, 1, 64'h2004,       1, 32'h77777777, 64'h2000));
    vecs.push_back(mk("F6", 0, 1, 0, 32'h0,        0, 64'h0,          1, 2, 0, 64'h2000,       0, 32'h0,        64'h0));
    vecs.push_back(mk("F7", 0, 1, 0, 32'h0,        0, 64'h0,          1, 1, 1, 64'h2000,       0, 32'h0,        64'h0));
    // G: redirect from IDLE to the top word, pc wraps to zero
    vecs.push_back(mk("G0", 1, 0, 0, 32'h0,        0, 64'h0,          0, 0, 0, 64'h0,          0, 32'h0,        64'h0));
    vecs.push_back(mk("G1", 0, 0, 0, 32'h0,        1, 64'hFFFFFFFFFFFFFFFF, 0, 1, 0, 64'h0,    0, 32'h0,        64'h0));
    vecs.push_back(mk("G2", 0, 1, 0, 32'h0,        0, 64'h0,          0, 1, 1, 64'hFFFFFFFFFFFFFFFC, 0, 32'h0,  64'h0));
    vecs.push_back(mk("G3", 0, 1, 1, 32'h99999999, 0, 64'h0,          0, 1, 0, 64'h0,          0, 32'h0,        64'h0));
    vecs.push_back(mk("G4", 0, 0, 0, 32'h0,        0, 64'h0,          0, 1, 1, 64'h0,          1, 32'h99999999, 64'hFFFFFFFFFFFFFFFC));

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply_vec(vecs[i]);
    end

    // C: memory holds off the first request for five cycles
    apply_vec(mk("C0", 1, 0, 0, 32'h0, 0, 64'h0, 0, 0, 0, 64'h0, 0, 32'h0, 64'h0));
    apply_vec(mk("C1", 0, 0, 0, 32'h0, 0, 64'h0, 0, 1, 0, 64'h0, 0, 32'h0, 64'h0));
    for (int k = 0; k < 5; k++) begin
      apply_vec(mk($sformatf("C_stall%0d", k), 0, 0, 0, 32'h0, 0, 64'h0, 0, 1, 1, 64'h2000, 0, 32'h0, 64'h0));
    end
    apply_vec(mk("C7", 0, 1, 0, 32'h0,        0, 64'h0, 0, 1, 1, 64'h2000, 0, 32'h0,        64'h0));
    apply_vec(mk("C8", 0, 0, 1, 32'hAAAA0000, 0, 64'h0, 0, 1, 0, 64'h0,    0, 32'h0,        64'h0));
    apply_vec(mk("C9", 0, 0, 0, 32'h0,        0, 64'h0, 0, 1, 1, 64'h2004, 1, 32'hAAAA0000, 64'h2000));

    // H: redirect while a request is stalled in REQ; the request stays up,
    // its handshake does not advance pc, and its response is dropped.
    apply_vec(mk("H0", 1, 0, 0, 32'h0,        0, 64'h0,    0, 0, 0, 64'h0,    0, 32'h0,        64'h0));
    apply_vec(mk("H1", 0, 0, 0, 32'h0,        0, 64'h0,    0, 1, 0, 64'h0,    0, 32'h0,        64'h0));
    apply_vec(mk("H2", 0, 0, 0, 32'h0,        1, 64'h5000, 0, 1, 1, 64'h2000, 0, 32'h0,        64'h0));
    apply_vec(mk("H3", 0, 1, 0, 32'h0,        0, 64'h0,    0, 1, 1, 64'h2000, 0, 32'h0,        64'h0));
    apply_vec(mk("H4", 0, 1, 1, 32'hDEADBEEF, 0, 64'h0,    0, 1, 0, 64'h0,    0, 32'h0,        64'h0));
    apply_vec(mk("H5", 0, 1, 0, 32'h0,        0, 64'h0,    0, 1, 1, 64'h5000, 0, 32'h0,        64'h0));
    apply_vec(mk("H6", 0, 1, 1, 32'h5555AAAA, 0, 64'h0,    0, 1, 0, 64'h0,    0, 32'h0,        64'h0));
    apply_vec(mk("H7", 0, 0, 0, 32'h0,        0, 64'h0,    0, 1, 1, 64'h5004, 1, 32'h5555AAAA, 64'h5000));

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
